alu_request_arbiter: RTL and testbench

Two-requester front end for the shared 8-bit `arithmetic_logic_unit`. It accepts operation requests over valid/ready handshakes and grants the single ALU instance round-robin. It holds the selected operands stable for one evaluation cycle, registers the result and carry, and returns them to the owning requester over a valid/ready response handshake. It sits between the two datapath clients and the ALU, which it instantiates internally.

---
 rtl/alu_request_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_request_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_request_arbiter.sv
// Round-robin front end sharing one 8-bit ALU between two requesters.
// Operands are held for one EXEC cycle; result returns over a response handshake.
module arithmetic_logic_unit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] operation_select,
    output logic [7:0] result_output,
    output logic       carry_flag
);
    logic [8:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        carry_flag = sum[8];
        result_output = 8'h00;
        unique case (operation_select)
            4'h0: result_output = sum[7:0];
            4'h1: result_output = a - b;
            4'h2: result_output = a * b;
            4'h3: result_output = (b == 8'h00) ? 8'h00 : a / b;
            4'h4: result_output = a << 1;
            4'h5: result_output = a >> 1;
            4'h6: result_output = {a[6:0], a[7]};
            4'h7: result_output = {a[0], a[7:1]};
            4'h8: result_output = a & b;
            4'h9: result_output = a | b;
            4'hA: result_output = a ^ b;
            4'hB: result_output = ~(a | b);
            4'hC: result_output = ~(a & b);
            4'hD: result_output = ~(a ^ b);
            4'hE: result_output = (a > b) ? 8'h01 : 8'h00;
            4'hF: result_output = (a == b) ? 8'h01 : 8'h00;
            default: result_output = 8'h00;
        endcase
    end
endmodule

module alu_request_arbiter #(
    parameter logic [15:0] OP_ENABLE_MASK = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [3:0]  req1_op,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [7:0]  resp_result,
    output logic        resp_carry,
    output logic        resp_error,
    output logic [15:0] ops_completed
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_grant, owner;
    logic [7:0]  opa_q, opb_q;
    logic [3:0]  op_q;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic [15:0] count_q;
    logic        win0, win1, accept, resp_take;

    arithmetic_logic_unit u_alu (
        .a                (opa_q),
        .b                (opb_q),
        .operation_select (op_q),
        .result_output    (alu_result),
        .carry_flag       (alu_carry)
    );

    // On a tie the requester that was not served last wins.
    always_comb begin
        win0 = req0_valid && (!req1_valid || last_grant);
        win1 = req1_valid && (!req0_valid || !last_grant);
        req0_ready = !rst && (state_q == IDLE) && win0;
        req1_ready = !rst && (state_q == IDLE) && win1;
        accept = req0_ready || req1_ready;
        resp_take = owner ? resp1_ready : resp0_ready;
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            opa_q       <= 8'h00;
            opb_q       <= 8'h00;
            op_q        <= 4'h0;
            resp_result <= 8'h00;
            resp_carry  <= 1'b0;
            resp_error  <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            count_q     <= 16'h0000;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner <= req1_ready;
                        opa_q <= req1_ready ? req1_a : req0_a;
                        opb_q <= req1_ready ? req1_b : req0_b;
                        op_q  <= req1_ready ? req1_op : req0_op;
                    end
                end
                EXEC: begin
                    if (OP_ENABLE_MASK[op_q]) begin
                        resp_result <= alu_result;
                        resp_carry  <= alu_carry;
                        resp_error  <= 1'b0;
                    end else begin
                        resp_result <= 8'h00;
                        resp_carry  <= 1'b0;
                        resp_error  <= 1'b1;
                    end
                    resp0_valid <= !owner;
                    resp1_valid <= owner;
                end
                RESP: begin
                    if (resp_take) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        last_grant  <= owner;
                        count_q     <= count_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ops_completed = count_q;
endmodule

// File: tb/tb_alu_request_arbiter.sv
// Bench for alu_request_arbiter: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_alu_request_arbiter;
    localparam logic [15:0] MASK = 16'hF7EF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [7:0]  resp_result;
    logic        resp_carry, resp_error;
    logic [15:0] ops_completed;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit preload = 1'b0;

    alu_request_arbiter #(.OP_ENABLE_MASK(MASK)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_carry(resp_carry),
        .resp_error(resp_error), .ops_completed(ops_completed)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {carry, result} of the ALU operation set
    function automatic logic [8:0] ref_alu(logic [7:0] a, logic [7:0] b, logic [3:0] op);
        int ia, ib, r;
        ia = a;
        ib = b;
        case (op)
            4'h0: r = ia + ib;
            4'h1: r = ia - ib;
            4'h2: r = ia * ib;
            4'h3: r = (ib == 0) ? 0 : ia / ib;
            4'h4: r = ia * 2;
            4'h5: r = ia / 2;
            4'h6: r = ia * 2 + ia / 128;
            4'h7: r = ia / 2 + (ia % 2) * 128;
            4'h8: r = ia & ib;
            4'h9: r = ia | ib;
            4'hA: r = ia ^ ib;
            4'hB: r = ~(ia | ib);
            4'hC: r = ~(ia & ib);
            4'hD: r = ~(ia ^ ib);
            4'hE: r = (ia > ib) ? 1 : 0;
            default: r = (ia == ib) ? 1 : 0;
        endcase
        return {((ia + ib) > 255) ? 1'b1 : 1'b0, r[7:0]};
    endfunction

    function automatic int winner(logic v0, logic v1, logic last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Reference model: one outstanding transaction, aged in cycles since accept
    bit          m_busy, m_owner, m_last, m_car, m_err, p_car, p_err;
    int          m_age;
    logic [7:0]  m_res, p_res;
    logic [15:0] m_count;

    always @(posedge clk or posedge rst) begin
        int w;
        logic [8:0] r;
        if (rst) begin
            m_busy = 0; m_age = 0; m_owner = 0; m_last = 1;
            m_res = 8'h00; m_car = 0; m_err = 0; m_count = 16'h0000;
        end else if (preload) begin
            m_count = 16'hFFFF;
        end else if (!m_busy) begin
            w = winner(req0_valid, req1_valid, m_last);
            if (w >= 0) begin
                m_busy = 1;
                m_age = 1;
                m_owner = (w == 1);
                r = (w == 1) ? ref_alu(req1_a, req1_b, req1_op)
                             : ref_alu(req0_a, req0_b, req0_op);
                if (MASK[(w == 1) ? req1_op : req0_op]) begin
                    p_res = r[7:0]; p_car = r[8]; p_err = 0;
                end else begin
                    p_res = 8'h00; p_car = 0; p_err = 1;
                end
            end
        end else if (m_age == 1) begin
            m_age = 2;
            m_res = p_res; m_car = p_car; m_err = p_err;
        end else if (m_owner ? resp1_ready : resp0_ready) begin
            m_busy = 0;
            m_last = m_owner;
            m_count = m_count + 16'd1;
        end
    end

    always @(negedge clk) begin
        int w;
        if (chk_en) begin
            w = (rst || m_busy) ? -1 : winner(req0_valid, req1_valid, m_last);
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, w == 0});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, w == 1});
            chk("resp0_valid", {31'd0, resp0_valid}, {31'd0, m_busy && m_age >= 2 && !m_owner});
            chk("resp1_valid", {31'd0, resp1_valid}, {31'd0, m_busy && m_age >= 2 && m_owner});
            chk("resp_result", {24'd0, resp_result}, {24'd0, m_res});
            chk("resp_carry", {31'd0, resp_carry}, {31'd0, m_car});
            chk("resp_error", {31'd0, resp_error}, {31'd0, m_err});
            chk("ops_completed", {16'd0, ops_completed}, {16'd0, m_count});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc0, acc1, prev, g, have_prev;
        clear_inputs();
        rst = 1;
        #12;
        chk_en = 1;
        // ready must stay low under reset even with valid asserted
        req0_valid = 1;
        #1;
        chk("rst_req0_ready", {31'd0, req0_ready}, 0);
        chk("rst_count", {16'd0, ops_completed}, 0);
        chk("rst_resp0_valid", {31'd0, resp0_valid}, 0);
        chk("rst_result", {24'd0, resp_result}, 0);

        // addition
        do_reset();
        req0_valid = 1; req0_a = 8'h0F; req0_b = 8'hF0; req0_op = 4'h0; resp0_ready = 1;
        #1;
        chk("add_req0_ready", {31'd0, req0_ready}, 1);
        step(); req0_valid = 0; #1;
        chk("add_exec_no_valid", {31'd0, resp0_valid}, 0);
        step();
        chk("add_resp0_valid", {31'd0, resp0_valid}, 1);
        chk("add_result", {24'd0, resp_result}, 32'hFF);
        chk("add_carry", {31'd0, resp_carry}, 0);
        chk("add_error", {31'd0, resp_error}, 0);
        step();
        chk("add_count", {16'd0, ops_completed}, 1);
        chk("add_resp_done", {31'd0, resp0_valid}, 0);

        // simultaneous requests
        do_reset();
        req0_valid = 1; req0_a = 8'h03; req0_b = 8'h04; req0_op = 4'h2;
        req1_valid = 1; req1_a = 8'hFF; req1_b = 8'h0F; req1_op = 4'h8;
        resp0_ready = 1; resp1_ready = 1;
        #1;
        chk("tie_req0_ready", {31'd0, req0_ready}, 1);
        chk("tie_req1_ready", {31'd0, req1_ready}, 0);
        step(); req0_valid = 0;
        step();
        chk("tie_resp0_valid", {31'd0, resp0_valid}, 1);
        chk("tie_result0", {24'd0, resp_result}, 32'h0C);
        step();
        chk("tie_req1_ready_next", {31'd0, req1_ready}, 1);
        step(); req1_valid = 0;
        step();
        chk("tie_resp1_valid", {31'd0, resp1_valid}, 1);
        chk("tie_result1", {24'd0, resp_result}, 32'h0F);
        chk("tie_carry1", {31'd0, resp_carry}, 1);
        step();

        // continuous contention alternates grants
        req0_valid = 1; req1_valid = 1;
        have_prev = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                g = req1_ready;
                if (have_prev) chk("alternate", {31'd0, g}, {31'd0, !prev});
                prev = g;
                have_prev = 1;
            end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (4) step();

        // back-pressure
        do_reset();
        req0_valid = 1; req0_a = 8'h0A; req0_b = 8'h03; req0_op = 4'h1;
        req1_valid = 1; req1_a = 8'h01; req1_b = 8'h02; req1_op = 4'h0;
        resp1_ready = 1;
        step(); req0_valid = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp0_valid", {31'd0, resp0_valid}, 1);
            chk("bp_result", {24'd0, resp_result}, 32'h07);
            chk("bp_carry", {31'd0, resp_carry}, 0);
            chk("bp_req1_ready", {31'd0, req1_ready}, 0);
            step();
        end
        resp0_ready = 1;
        step();
        chk("bp_req1_accept", {31'd0, req1_ready}, 1);
        step(); req1_valid = 0;
        repeat (3) step();

        // disabled opcode
        do_reset();
        req1_valid = 1; req1_a = 8'hAA; req1_b = 8'h00; req1_op = 4'h4; resp1_ready = 1;
        step(); req1_valid = 0;
        step();
        chk("dis_resp1_valid", {31'd0, resp1_valid}, 1);
        chk("dis_result", {24'd0, resp_result}, 0);
        chk("dis_carry", {31'd0, resp_carry}, 0);
        chk("dis_error", {31'd0, resp_error}, 1);
        step();
        chk("dis_count", {16'd0, ops_completed}, 1);

        // reset in the middle of an operation
        req0_valid = 1; req0_a = 8'h05; req0_b = 8'h06; req0_op = 4'h0; resp0_ready = 1;
        step(); req0_valid = 0;
        step();
        chk("pre_rst_result", {24'd0, resp_result}, 32'h0B);
        step();
        chk("pre_rst_count", {16'd0, ops_completed}, 2);
        req1_valid = 1; req1_a = 8'h80; req1_b = 8'h80; req1_op = 4'h0;
        step(); req1_valid = 0;
        #1; rst = 1; #1;
        chk("mid_rst_result", {24'd0, resp_result}, 0);
        chk("mid_rst_count", {16'd0, ops_completed}, 0);
        chk("mid_rst_error", {31'd0, resp_error}, 0);
        chk("mid_rst_resp1", {31'd0, resp1_valid}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_resp1", {31'd0, resp1_valid}, 0);
        end
        req0_valid = 1; req1_valid = 1; #1;
        chk("post_rst_tie", {31'd0, req0_ready}, 1);
        step(); req0_valid = 0; req1_valid = 0;
        repeat (4) step();

        // counter wrap
        do_reset();
        chk_en = 0;
        @(posedge clk); #2;
        preload = 1;
        force dut.count_q = 16'hFFFF;
        #1 release dut.count_q;
        step();
        preload = 0;
        chk_en = 1;
        chk("wrap_preload", {16'd0, ops_completed}, 32'hFFFF);
        req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 4'h9; resp0_ready = 1;
        step(); req0_valid = 0;
        step();
        step();
        chk("wrap_count", {16'd0, ops_completed}, 0);

        // randomized traffic with protocol-legal requesters
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (req0_valid && !acc0) begin
                if ($urandom_range(0, 15) == 0) req0_valid = 0;
            end else begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a = 8'($urandom); req0_b = 8'($urandom);
                req0_op = 4'($urandom_range(0, 15));
            end
            if (req1_valid && !acc1) begin
                if ($urandom_range(0, 15) == 0) req1_valid = 0;
            end else begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a = 8'($urandom); req1_b = 8'($urandom);
                req1_op = 4'($urandom_range(0, 15));
            end
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
        end
        clear_inputs();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
